grad_scan_ctrl: RTL and testbench
=================================

// Module: grad_scan_ctrl
// PURPOSE
//  Frame-level sequencer for the gradient (dx/dy) datapath. On start, it reads one
//  IMG_W x IMG_H 8-bit frame from pixel RAM in raster order and feeds it to the datapath
//  as din plus enable (complete1). It counts the datapath's out_en strobes, generates
//  write addresses for the gradient store, and reports done or a drain-timeout error.
// PARAMETERS
//  IMG_W      64    frame width in pixels (>=3)
//  IMG_H      64    frame height in lines (>=3)
//  ADDR_W     12    pixel / gradient RAM address width; 2**ADDR_W >= IMG_W*IMG_H
//  OUT_NUM    (IMG_W-2)*(IMG_H-2)  expected out_en strobes per frame
//  DRAIN_MAX  255   max idle cycles in DRAIN before declaring timeout
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  start      in   1       1-cycle pulse; ignored unless state==IDLE
//  hold       in   1       1 = pause pixel issue (downstream back-pressure)
//  rd_en      out  1       pixel RAM read strobe
//  rd_addr    out  ADDR_W  pixel RAM read address
//  rd_data    in   8       pixel RAM data, valid 1 cycle after rd_en
//  pix_out    out  8       -> datapath din
//  pix_en     out  1       -> datapath complete1 (pixel valid)
//  grad_vld   in   1       <- datapath out_en
//  wr_en      out  1       gradient store write strobe (= grad_vld while busy)
//  wr_addr    out  ADDR_W  gradient store address, 0..OUT_NUM-1
//  busy       out  1       high from the cycle after start until done/err
//  done       out  1       1-cycle pulse, frame complete
//  err        out  1       sticky drain-timeout flag; cleared by the next accepted start
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE. rd_en, pix_en, wr_en, busy, done, err = 0.
//   rd_addr, wr_addr, pix_out = 0. All counters = 0.
//  FSM: IDLE -> READ -> DRAIN -> FIN -> IDLE.
//   IDLE : on start, clear counters and err; next state READ; busy=1 next cycle.
//   READ : each cycle with hold=0: rd_en=1, rd_addr=rd_cnt, rd_cnt++.
//          With hold=1: rd_en=0 and rd_addr is held.
//          After the issue with rd_cnt==IMG_W*IMG_H-1 -> DRAIN.
//   DRAIN: no reads. idle_cnt++ each cycle without grad_vld; cleared on grad_vld.
//          out_cnt==OUT_NUM -> FIN.
//          idle_cnt==DRAIN_MAX -> FIN with err=1.
//   FIN  : done=1 for 1 cycle, busy=0, -> IDLE.
//  Read pipeline: pix_en(t+1)=rd_en(t); pix_out(t+1)=rd_data(t+1) registered at t+2?
//   No. pix_out is combinational from rd_data and pix_en is the registered rd_en, so
//   pixel-to-datapath latency is exactly 1 cycle from rd_en.
//  Gradient path: in READ/DRAIN, wr_en=grad_vld (combinational), wr_addr=out_cnt.
//   out_cnt increments on each grad_vld.
//   grad_vld beyond OUT_NUM, or while IDLE, is ignored: no wr_en, no count.
//  Simultaneous: a grad_vld in the same cycle out_cnt reaches OUT_NUM is counted, then
//   the FSM goes to FIN. Exit on count takes priority over timeout in the same cycle.
//  A start while busy is ignored (no restart).
//  hold has no effect in DRAIN.
//  Address counters never wrap within a frame. rd_cnt stops at IMG_W*IMG_H-1.
//  Reset mid-frame aborts immediately to IDLE; no done pulse is produced.
// CONFIGURATION
//  SCAN_PERF_EN defined: adds output perf_cyc [23:0]. It is cleared on an accepted
//   start, increments every busy cycle (saturates at 24'hFFFFFF), and holds its value
//   after done. Reset value is 0.
//  SCAN_PERF_EN undefined: no perf_cyc port and no counter logic.
// TESTING  (IMG_W=8, IMG_H=6, OUT_NUM=24, DRAIN_MAX=16)
//  1 reset/idle: rst=0 then 1, no start -> all outputs 0 for 20 cycles.
//  2 clean frame: start, hold=0, model asserts grad_vld 24 times
//    -> 48 rd_en with addresses 0..47 in consecutive cycles; pix_en trails rd_en by 1;
//       wr_addr 0..23; done pulse once; err=0.
//  3 back-pressure: hold=1 for cycles 10-14 of READ -> rd_addr frozen, pix_en=0 for 5
//    cycles, total reads still 48, done still asserted.
//  4 timeout: model asserts grad_vld only 20 times -> after 16 idle cycles in DRAIN:
//    done=1, err=1. The next start clears err.
//  5 start while busy: a second start at read 30 -> ignored; rd_addr continues 31..47.
//  6 reset mid-frame: rst=0 at read 20 -> busy/rd_en drop asynchronously; no done;
//    a new start then reads from address 0.

Source files
------------

// File: rtl/grad_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : grad_scan_ctrl_if
//  Purpose  : Bundles the pixel-RAM read port, the datapath feed, the gradient
//             store write port and the control/status lines of grad_scan_ctrl.
//             master = the sequencer, slave = the surrounding system.
//  Revision : 1.0  initial release
// ============================================================================
interface grad_scan_ctrl_if #(
    parameter int ADDR_W = 12
) ();
    // Control / status
    logic              start;
    logic              hold;
    logic              busy;
    logic              done;
    logic              err;
    // Pixel RAM read port
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    // Datapath feed
    logic [7:0]        pix_out;
    logic              pix_en;
    // Gradient store write port
    logic              grad_vld;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    modport master (
        input  start, hold, rd_data, grad_vld,
        output rd_en, rd_addr, pix_out, pix_en, wr_en, wr_addr, busy, done, err
    );

    modport slave (
        output start, hold, rd_data, grad_vld,
        input  rd_en, rd_addr, pix_out, pix_en, wr_en, wr_addr, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/grad_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : grad_scan_ctrl
//  Purpose  : Frame sequencer for the dx/dy gradient datapath. Reads one
//             IMG_W x IMG_H frame from pixel RAM in raster order, feeds it to
//             the datapath, numbers the returned gradients for the store and
//             reports done or a drain timeout (err).
//  Options  : SCAN_PERF_EN - adds the perf_cyc busy-cycle counter output.
//  Revision : 1.0  initial release
// ============================================================================
module grad_scan_ctrl #(
    parameter int IMG_W     = 64,
    parameter int IMG_H     = 64,
    parameter int ADDR_W    = 12,
    parameter int OUT_NUM   = (IMG_W - 2) * (IMG_H - 2),
    parameter int DRAIN_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    grad_scan_ctrl_if.master bus
`ifdef SCAN_PERF_EN
    ,
    output logic [23:0]      perf_cyc
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam int                c_idle_w     = $clog2(DRAIN_MAX + 1);
    localparam logic [ADDR_W-1:0] c_pix_last   = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] c_out_num    = ADDR_W'(OUT_NUM);
    // The idle counter trips on the cycle that would make it reach DRAIN_MAX.
    localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(DRAIN_MAX - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_rd_cnt;
    logic [ADDR_W-1:0]   w_rd_cnt_nxt;
    logic [ADDR_W-1:0]   r_out_cnt;
    logic [ADDR_W-1:0]   w_out_cnt_nxt;
    logic [c_idle_w-1:0] r_idle_cnt;
    logic [c_idle_w-1:0] w_idle_cnt_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic                r_pix_en;
    logic                w_rd_en;
    logic                w_busy;
    logic                w_done;
    logic                w_grad_acc;
    logic                w_start_acc;

    // FSM state and frame counters; reset aborts a frame with no done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_rd_cnt   <= '0;
            r_out_cnt  <= '0;
            r_idle_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
            r_out_cnt  <= w_out_cnt_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Next-state, counter updates and strobes for the frame sequence.
    always_comb begin
        w_state_nxt    = r_state;
        w_rd_cnt_nxt   = r_rd_cnt;
        w_out_cnt_nxt  = r_out_cnt;
        w_idle_cnt_nxt = r_idle_cnt;
        w_err_nxt      = r_err;
        w_rd_en        = 1'b0;
        w_busy         = 1'b0;
        w_done         = 1'b0;
        w_grad_acc     = 1'b0;
        w_start_acc    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_start_acc    = 1'b1;
                    w_rd_cnt_nxt   = '0;
                    w_out_cnt_nxt  = '0;
                    w_idle_cnt_nxt = '0;
                    w_err_nxt      = 1'b0;
                    w_state_nxt    = ST_READ;
                end
            end

            ST_READ: begin
                w_busy     = 1'b1;
                // Gradients may already return while the frame is being read.
                w_grad_acc = bus.grad_vld && (r_out_cnt < c_out_num);
                if (w_grad_acc) begin
                    w_out_cnt_nxt = r_out_cnt + ADDR_W'(1);
                end
                if (!bus.hold) begin
                    w_rd_en = 1'b1;
                    // The last address is issued once and the counter parks there.
                    if (r_rd_cnt == c_pix_last) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_rd_cnt_nxt = r_rd_cnt + ADDR_W'(1);
                    end
                end
            end

            ST_DRAIN: begin
                w_busy     = 1'b1;
                w_grad_acc = bus.grad_vld && (r_out_cnt < c_out_num);
                if (w_grad_acc) begin
                    w_out_cnt_nxt = r_out_cnt + ADDR_W'(1);
                end
                // Completing the count wins over a timeout in the same cycle.
                if (w_out_cnt_nxt == c_out_num) begin
                    w_state_nxt = ST_FIN;
                end else if (w_grad_acc) begin
                    w_idle_cnt_nxt = '0;
                end else if (r_idle_cnt == c_idle_last) begin
                    w_idle_cnt_nxt = r_idle_cnt + c_idle_w'(1);
                    w_err_nxt      = 1'b1;
                    w_state_nxt    = ST_FIN;
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + c_idle_w'(1);
                end
            end

            ST_FIN: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pixel-valid trails the read strobe by the one-cycle RAM latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_en <= 1'b0;
        end else begin
            r_pix_en <= w_rd_en;
        end
    end

    assign bus.rd_en   = w_rd_en;
    assign bus.rd_addr = r_rd_cnt;
    // RAM data passes straight through; forced to zero when not valid.
    assign bus.pix_out = r_pix_en ? bus.rd_data : 8'h00;
    assign bus.pix_en  = r_pix_en;
    assign bus.wr_en   = w_grad_acc;
    assign bus.wr_addr = r_out_cnt;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.err     = r_err;

`ifdef SCAN_PERF_EN
    logic [23:0] r_perf_cyc;

    // Busy-cycle counter: cleared on an accepted start, saturating, held after done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_cyc <= '0;
        end else if (w_start_acc) begin
            r_perf_cyc <= '0;
        end else if (w_busy && (r_perf_cyc != 24'hFFFFFF)) begin
            r_perf_cyc <= r_perf_cyc + 24'd1;
        end
    end

    assign perf_cyc = r_perf_cyc;
`else
    // Start acceptance only feeds the optional performance counter.
    logic w_unused;
    assign w_unused = w_start_acc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_grad_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_grad_scan_ctrl
//  Purpose  : Self-checking bench for grad_scan_ctrl on an 8x6 frame with
//             randomized pixel data, hold and gradient-return timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_grad_scan_ctrl;
    localparam int IMG_W     = 8;
    localparam int IMG_H     = 6;
    localparam int ADDR_W    = 12;
    localparam int OUT_NUM   = 24;
    localparam int DRAIN_MAX = 16;
    localparam int NPIX      = IMG_W * IMG_H;
    localparam int MAXC      = 400;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    grad_scan_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
`ifdef SCAN_PERF_EN
    logic [23:0] perf_cyc;
`endif

    grad_scan_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
        .OUT_NUM(OUT_NUM), .DRAIN_MAX(DRAIN_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef SCAN_PERF_EN
        ,
        .perf_cyc(perf_cyc)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] mem [NPIX];

    // Per-frame observation record
    int   obs_rd_addr[$];
    int   obs_rd_cyc[$];
    int   obs_pix[$];
    int   obs_wr_addr[$];
    int   obs_grad_cyc[$];
    int   exp_rd_cyc[$];
    int   ncyc, done_cnt, done_cyc;
    logic err_at_done, rst_busy, rst_rd_en;
    logic tr_rd_en [MAXC];
    int   tr_rd_addr [MAXC];
    logic tr_pix_en [MAXC];
    logic tr_busy [MAXC];
    logic tr_hold [MAXC];
    logic tr_err [MAXC];

    task automatic fill_mem();
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    endtask

    // Drives one frame: start at cycle 0, optional hold window or random hold,
    // n_grad gradient strobes with random gaps, optional second start or reset.
    task automatic run_frame(input int n_grad, input int hold_lo, input int hold_hi,
                             input bit rand_hold, input int restart_at,
                             input int rst_at, input int max_cyc);
        int   sent = 0;
        int   next_grad;
        logic prev_rd_en = 1'b0;
        int   prev_rd_addr = 0;
        bit   restarted = 1'b0;
        obs_rd_addr.delete(); obs_rd_cyc.delete(); obs_pix.delete();
        obs_wr_addr.delete(); obs_grad_cyc.delete();
        ncyc = 0; done_cnt = 0; done_cyc = -1;
        err_at_done = 1'bx; rst_busy = 1'bx; rst_rd_en = 1'bx;
        next_grad = $urandom_range(3, 12);
        for (int c = 0; c < max_cyc; c++) begin
            bus.start = (c == 0);
            if (restart_at >= 0 && !restarted && c > 0 && obs_rd_addr.size() == restart_at) begin
                bus.start = 1'b1;
                restarted = 1'b1;
            end
            bus.hold = rand_hold ? ($urandom_range(0, 3) == 0)
                                 : (c - 1 >= hold_lo && c - 1 <= hold_hi);
            bus.grad_vld = (c >= next_grad) && (sent < n_grad);
            if (rst_at >= 0 && obs_rd_addr.size() == rst_at) begin
                rst = 1'b0;
                #1;
                rst_busy  = bus.busy;
                rst_rd_en = bus.rd_en;
                bus.start = 1'b0; bus.hold = 1'b0; bus.grad_vld = 1'b0;
                @(posedge clk); #1;
                rst  = 1'b1;
                ncyc = c;
                break;
            end
            #1;
            tr_rd_en[c]   = bus.rd_en;
            tr_rd_addr[c] = int'(bus.rd_addr);
            tr_pix_en[c]  = bus.pix_en;
            tr_busy[c]    = bus.busy;
            tr_hold[c]    = bus.hold;
            tr_err[c]     = bus.err;
            if (bus.rd_en) begin
                obs_rd_addr.push_back(int'(bus.rd_addr));
                obs_rd_cyc.push_back(c);
            end
            if (bus.pix_en) obs_pix.push_back(int'(bus.pix_out));
            if (bus.wr_en)  obs_wr_addr.push_back(int'(bus.wr_addr));
            if (bus.grad_vld) begin
                obs_grad_cyc.push_back(c);
                sent++;
                next_grad = c + $urandom_range(1, 3);
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc    = c;
                    err_at_done = bus.err;
                end
            end
            prev_rd_en   = bus.rd_en;
            prev_rd_addr = int'(bus.rd_addr);
            ncyc = c + 1;
            @(posedge clk); #1;
            bus.rd_data = (prev_rd_en && prev_rd_addr < NPIX) ? mem[prev_rd_addr] : 8'($urandom);
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        bus.start = 1'b0; bus.hold = 1'b0; bus.grad_vld = 1'b0;
    endtask

    // Reference: read k is issued on the k-th non-hold cycle after start.
    task automatic build_read_model();
        exp_rd_cyc.delete();
        for (int c = 1; c < ncyc && exp_rd_cyc.size() < NPIX; c++)
            if (!tr_hold[c]) exp_rd_cyc.push_back(c);
    endtask

    // Reference done cycle: one cycle after both the last read and the final
    // gradient are in; on timeout, DRAIN_MAX idle cycles after the last activity.
    function automatic int model_done(input int n_grad);
        int d, g, l;
        if (exp_rd_cyc.size() < NPIX) return -2;
        d = exp_rd_cyc[NPIX-1] + 1;
        if (n_grad >= OUT_NUM) begin
            if (obs_grad_cyc.size() < OUT_NUM) return -3;
            g = obs_grad_cyc[OUT_NUM-1];
            return ((g > d) ? g : d) + 1;
        end
        g = (obs_grad_cyc.size() > 0) ? obs_grad_cyc[obs_grad_cyc.size()-1] : -1;
        l = (g + 1 > d) ? g + 1 : d;
        return l + DRAIN_MAX;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0; bus.hold = 1'b0; bus.grad_vld = 1'b0; bus.rd_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.grad_vld = 1'($urandom_range(0, 1));
            bus.hold     = 1'($urandom_range(0, 1));
            bus.rd_data  = 8'($urandom);
            #1;
            n_total++;
            if ({bus.rd_en, bus.rd_addr, bus.pix_out, bus.pix_en, bus.wr_en,
                 bus.wr_addr, bus.busy, bus.done, bus.err} !== '0)
                $display("FAIL reset_idle cyc %0d: rd_en=%b rd_addr=%0d pix_out=%0h pix_en=%b wr_en=%b wr_addr=%0d busy=%b done=%b err=%b, expected all 0",
                         i, bus.rd_en, bus.rd_addr, bus.pix_out, bus.pix_en, bus.wr_en,
                         bus.wr_addr, bus.busy, bus.done, bus.err);
            else n_pass++;
            @(posedge clk); #1;
        end
        bus.grad_vld = 1'b0; bus.hold = 1'b0;
    endtask

    task automatic test_clean_frame();
        for (int f = 0; f < 3; f++) begin
            int bad = -1;
            int exp_done;
            fill_mem();
            run_frame(OUT_NUM, -1, -1, 1'b0, -1, -1, 300);
            build_read_model();
            exp_done = model_done(OUT_NUM);

            n_total++;
            if (obs_rd_addr.size() != NPIX)
                $display("FAIL clean_rd_count frame %0d: got %0d expected %0d", f, obs_rd_addr.size(), NPIX);
            else n_pass++;

            for (int i = 0; i < obs_rd_addr.size() && i < exp_rd_cyc.size(); i++)
                if (bad < 0 && (obs_rd_addr[i] != i || obs_rd_cyc[i] != i + 1)) bad = i;
            n_total++;
            if (bad >= 0)
                $display("FAIL clean_rd_seq frame %0d read %0d: got addr %0d cyc %0d expected addr %0d cyc %0d",
                         f, bad, obs_rd_addr[bad], obs_rd_cyc[bad], bad, bad + 1);
            else n_pass++;

            bad = -1;
            for (int c = 0; c < ncyc; c++)
                if (bad < 0 && tr_pix_en[c] !== ((c == 0) ? 1'b0 : tr_rd_en[c-1])) bad = c;
            n_total++;
            if (bad >= 0)
                $display("FAIL clean_pix_lag frame %0d cyc %0d: got pix_en %b expected %b",
                         f, bad, tr_pix_en[bad], (bad == 0) ? 1'b0 : tr_rd_en[bad-1]);
            else n_pass++;

            bad = (obs_pix.size() == NPIX) ? -1 : NPIX;
            for (int i = 0; i < obs_pix.size() && i < NPIX; i++)
                if (bad < 0 && obs_pix[i] != int'(mem[i])) bad = i;
            n_total++;
            if (bad >= 0)
                $display("FAIL clean_pix_data frame %0d idx %0d: got %0d pixels, value %0h expected %0h",
                         f, bad, obs_pix.size(), (bad < obs_pix.size()) ? obs_pix[bad] : -1,
                         (bad < NPIX) ? int'(mem[bad]) : -1);
            else n_pass++;

            bad = (obs_wr_addr.size() == OUT_NUM) ? -1 : OUT_NUM;
            for (int i = 0; i < obs_wr_addr.size() && i < OUT_NUM; i++)
                if (bad < 0 && obs_wr_addr[i] != i) bad = i;
            n_total++;
            if (bad >= 0)
                $display("FAIL clean_wr_addr frame %0d: got %0d writes (first bad idx %0d) expected addresses 0..%0d",
                         f, obs_wr_addr.size(), bad, OUT_NUM - 1);
            else n_pass++;

            n_total++;
            if (done_cnt != 1 || done_cyc != exp_done || err_at_done !== 1'b0)
                $display("FAIL clean_done frame %0d: got %0d pulses at cyc %0d err %b expected 1 pulse at cyc %0d err 0",
                         f, done_cnt, done_cyc, err_at_done, exp_done);
            else n_pass++;

            bad = -1;
            for (int c = 0; c < ncyc; c++)
                if (bad < 0 && tr_busy[c] !== (c >= 1 && c < exp_done)) bad = c;
            n_total++;
            if (bad >= 0)
                $display("FAIL clean_busy frame %0d cyc %0d: got %b expected %b",
                         f, bad, tr_busy[bad], (bad >= 1 && bad < exp_done));
            else n_pass++;
`ifdef SCAN_PERF_EN
            n_total++;
            if (perf_cyc !== 24'(exp_done - 1))
                $display("FAIL perf_cyc frame %0d: got %0d expected %0d", f, perf_cyc, exp_done - 1);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_back_pressure();
        int bad = -1;
        int exp_done;
        fill_mem();
        // hold during READ cycles 10..14, i.e. bench cycles 11..15
        run_frame(OUT_NUM, 10, 14, 1'b0, -1, -1, 300);
        build_read_model();
        exp_done = model_done(OUT_NUM);

        for (int c = 11; c <= 15; c++)
            if (bad < 0 && (tr_rd_en[c] !== 1'b0 || tr_rd_addr[c] != 10)) bad = c;
        n_total++;
        if (bad >= 0)
            $display("FAIL bp_freeze cyc %0d: got rd_en %b rd_addr %0d expected rd_en 0 rd_addr 10",
                     bad, tr_rd_en[bad], tr_rd_addr[bad]);
        else n_pass++;

        bad = -1;
        for (int c = 12; c <= 16; c++) if (bad < 0 && tr_pix_en[c] !== 1'b0) bad = c;
        n_total++;
        if (bad >= 0) $display("FAIL bp_pix_en cyc %0d: got %b expected 0", bad, tr_pix_en[bad]);
        else n_pass++;

        bad = (obs_rd_addr.size() == NPIX && exp_rd_cyc.size() == NPIX) ? -1 : NPIX;
        for (int i = 0; i < obs_rd_addr.size() && i < exp_rd_cyc.size(); i++)
            if (bad < 0 && (obs_rd_addr[i] != i || obs_rd_cyc[i] != exp_rd_cyc[i])) bad = i;
        n_total++;
        if (bad >= 0)
            $display("FAIL bp_reads: got %0d reads (first bad idx %0d) expected %0d following hold gaps",
                     obs_rd_addr.size(), bad, NPIX);
        else n_pass++;

        n_total++;
        if (done_cnt != 1 || done_cyc != exp_done || err_at_done !== 1'b0)
            $display("FAIL bp_done: got %0d pulses at cyc %0d err %b expected 1 at cyc %0d err 0",
                     done_cnt, done_cyc, err_at_done, exp_done);
        else n_pass++;

        // random hold pattern
        for (int f = 0; f < 2; f++) begin
            fill_mem();
            run_frame(OUT_NUM, -1, -1, 1'b1, -1, -1, 300);
            build_read_model();
            exp_done = model_done(OUT_NUM);
            bad = (obs_rd_addr.size() == NPIX && obs_pix.size() == NPIX && exp_rd_cyc.size() == NPIX) ? -1 : NPIX;
            for (int i = 0; i < obs_rd_addr.size() && i < NPIX && i < obs_pix.size() && i < exp_rd_cyc.size(); i++)
                if (bad < 0 && (obs_rd_addr[i] != i || obs_rd_cyc[i] != exp_rd_cyc[i] || obs_pix[i] != int'(mem[i]))) bad = i;
            n_total++;
            if (bad >= 0)
                $display("FAIL bp_rand_stream frame %0d: got %0d reads %0d pixels (first bad idx %0d) expected %0d in order",
                         f, obs_rd_addr.size(), obs_pix.size(), bad, NPIX);
            else n_pass++;
            n_total++;
            if (done_cnt != 1 || done_cyc != exp_done || obs_wr_addr.size() != OUT_NUM)
                $display("FAIL bp_rand_done frame %0d: got %0d pulses at cyc %0d, %0d writes expected 1 at cyc %0d, %0d writes",
                         f, done_cnt, done_cyc, obs_wr_addr.size(), exp_done, OUT_NUM);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int exp_done;
        fill_mem();
        run_frame(20, -1, -1, 1'b0, -1, -1, 300);
        build_read_model();
        exp_done = model_done(20);

        n_total++;
        if (obs_wr_addr.size() != 20)
            $display("FAIL to_writes: got %0d expected 20", obs_wr_addr.size());
        else n_pass++;

        n_total++;
        if (done_cnt != 1 || done_cyc != exp_done || err_at_done !== 1'b1)
            $display("FAIL to_done: got %0d pulses at cyc %0d err %b expected 1 at cyc %0d err 1",
                     done_cnt, done_cyc, err_at_done, exp_done);
        else n_pass++;

        n_total++;
        if (ncyc < 1 || tr_err[ncyc-1] !== 1'b1)
            $display("FAIL to_err_sticky: got %b expected 1", (ncyc < 1) ? 1'bx : tr_err[ncyc-1]);
        else n_pass++;

        // next accepted start clears err
        fill_mem();
        run_frame(OUT_NUM, -1, -1, 1'b0, -1, -1, 300);
        build_read_model();
        exp_done = model_done(OUT_NUM);
        n_total++;
        if (tr_err[0] !== 1'b1 || tr_err[1] !== 1'b0)
            $display("FAIL to_err_clear: got err %b then %b expected 1 then 0", tr_err[0], tr_err[1]);
        else n_pass++;
        n_total++;
        if (done_cnt != 1 || done_cyc != exp_done || err_at_done !== 1'b0)
            $display("FAIL to_recover_done: got %0d pulses at cyc %0d err %b expected 1 at cyc %0d err 0",
                     done_cnt, done_cyc, err_at_done, exp_done);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int bad;
        int exp_done;
        fill_mem();
        run_frame(OUT_NUM, -1, -1, 1'b0, 30, -1, 300);
        build_read_model();
        exp_done = model_done(OUT_NUM);
        bad = (obs_rd_addr.size() == NPIX) ? -1 : NPIX;
        for (int i = 0; i < obs_rd_addr.size() && i < NPIX; i++)
            if (bad < 0 && (obs_rd_addr[i] != i || obs_rd_cyc[i] != i + 1)) bad = i;
        n_total++;
        if (bad >= 0)
            $display("FAIL swb_reads: got %0d reads (first bad idx %0d) expected addresses 0..%0d in cycles 1..%0d",
                     obs_rd_addr.size(), bad, NPIX - 1, NPIX);
        else n_pass++;
        n_total++;
        if (done_cnt != 1 || done_cyc != exp_done || tr_busy[32] !== 1'b1)
            $display("FAIL swb_done: got %0d pulses at cyc %0d busy_after_start %b expected 1 at cyc %0d busy 1",
                     done_cnt, done_cyc, tr_busy[32], exp_done);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        int exp_done;
        fill_mem();
        run_frame(OUT_NUM, -1, -1, 1'b0, -1, 20, 300);
        n_total++;
        if (rst_busy !== 1'b0 || rst_rd_en !== 1'b0)
            $display("FAIL rmf_async: got busy %b rd_en %b expected 0 0", rst_busy, rst_rd_en);
        else n_pass++;
        n_total++;
        if (done_cnt != 0 || obs_rd_addr.size() != 20)
            $display("FAIL rmf_abort: got %0d done pulses %0d reads expected 0 pulses 20 reads",
                     done_cnt, obs_rd_addr.size());
        else n_pass++;
        #1;
        n_total++;
        if ({bus.rd_en, bus.rd_addr, bus.pix_en, bus.wr_en, bus.wr_addr, bus.busy, bus.done, bus.err} !== '0)
            $display("FAIL rmf_idle: got rd_en=%b rd_addr=%0d pix_en=%b wr_en=%b wr_addr=%0d busy=%b done=%b err=%b expected all 0",
                     bus.rd_en, bus.rd_addr, bus.pix_en, bus.wr_en, bus.wr_addr, bus.busy, bus.done, bus.err);
        else n_pass++;
        @(posedge clk); #1;

        fill_mem();
        run_frame(OUT_NUM, -1, -1, 1'b0, -1, -1, 300);
        build_read_model();
        exp_done = model_done(OUT_NUM);
        bad = (obs_rd_addr.size() == NPIX) ? -1 : NPIX;
        for (int i = 0; i < obs_rd_addr.size() && i < NPIX; i++)
            if (bad < 0 && obs_rd_addr[i] != i) bad = i;
        n_total++;
        if (bad >= 0)
            $display("FAIL rmf_restart_reads: got %0d reads first addr %0d (bad idx %0d) expected %0d from 0",
                     obs_rd_addr.size(), (obs_rd_addr.size() > 0) ? obs_rd_addr[0] : -1, bad, NPIX);
        else n_pass++;
        n_total++;
        if (done_cnt != 1 || done_cyc != exp_done)
            $display("FAIL rmf_restart_done: got %0d pulses at cyc %0d expected 1 at cyc %0d",
                     done_cnt, done_cyc, exp_done);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.hold = 1'b0; bus.grad_vld = 1'b0; bus.rd_data = 8'h00;
        test_reset();
        test_clean_frame();
        test_back_pressure();
        test_timeout();
        test_start_while_busy();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
